// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared constants and bundle types for the register-file writeback controller.
// The widths here are the default configuration of the controller and its FIFO.
package rf_writeback_ctrl_pkg;

    localparam int RF_XLEN       = 32;
    localparam int RF_NREG       = 32;
    localparam int RF_AW         = 5;
    localparam int RF_FIFO_DEPTH = 2;

    typedef struct packed {
        logic                 we;
        logic [RF_AW-1:0]     addr;
        logic [RF_XLEN-1:0]   data;
    } wb_port_t;

    typedef struct packed {
        logic [RF_AW-1:0]     rd;
        logic [RF_XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Long-latency result handshake between the load/store unit (master) and the
// writeback controller (slave).
interface rf_writeback_ctrl_if
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int AW   = RF_AW,
    parameter int XLEN = RF_XLEN
) ();

    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_wdata;

    modport master (
        output lsu_valid,
        output lsu_rd,
        output lsu_wdata,
        input  lsu_ready
    );

    modport slave (
        input  lsu_valid,
        input  lsu_rd,
        input  lsu_wdata,
        output lsu_ready
    );

endinterface

// File: rtl/rf_writeback_ctrl_wb_result_fifo.sv
// Synchronous FIFO buffering long-latency results until the write port is free.
// A push is refused while full, even if a pop happens in the same cycle.
module wb_result_fifo
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int  DEPTH = RF_FIFO_DEPTH,
    parameter int  WIDTH = RF_AW + RF_XLEN,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Entry storage; validity is tracked by count_r, so data needs no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Drives the register file's single write port, merging the in-order ALU result
// with buffered long-latency completions, and tracks registers still owed a write.
module rf_writeback_ctrl
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int XLEN       = RF_XLEN,
    parameter int NREG       = RF_NREG,
    parameter int AW         = RF_AW,
    parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]      alu_wdata,
    rf_writeback_ctrl_if.slave   lsu,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic                 busy1,
    output logic                 busy2,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } port_t;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t           push_entry_s;
    entry_t           head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] unused_fifo_count_s;
    logic             alu_take_s;
    logic             fifo_pop_s;
    logic             head_live_s;
    port_t            port_r;
    port_t            port_nxt_s;
    logic [NREG-1:0]  pending_r;
    logic [NREG-1:0]  pending_nxt_s;

    assign push_entry_s  = '{rd: lsu.lsu_rd, data: lsu.lsu_wdata};
    assign lsu.lsu_ready = !fifo_full_s;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lsu.lsu_valid),
        .push_data (push_entry_s),
        .pop       (fifo_pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (unused_fifo_count_s)
    );

    // The pipeline cannot stall, so it always wins; an x0 ALU result is a bubble.
    assign alu_take_s  = alu_valid && (alu_rd != {AW{1'b0}});
    assign fifo_pop_s  = !alu_take_s && !fifo_empty_s;
    assign head_live_s = (head_s.rd != {AW{1'b0}});

    // Write-port arbitration; an idle slot holds addr/data and drops we.
    always_comb begin
        port_nxt_s    = port_r;
        port_nxt_s.we = 1'b0;
        if (alu_take_s) begin
            port_nxt_s.we   = 1'b1;
            port_nxt_s.addr = alu_rd;
            port_nxt_s.data = alu_wdata;
        end else if (fifo_pop_s) begin
            port_nxt_s.we   = head_live_s;
            port_nxt_s.addr = head_s.rd;
            port_nxt_s.data = head_s.data;
        end else begin
            port_nxt_s.we   = 1'b0;
        end
    end

    // Pending scoreboard; a same-cycle issue overrides the clear of an older op.
    always_comb begin
        pending_nxt_s = pending_r;
        if (fifo_pop_s && head_live_s) begin
            pending_nxt_s[head_s.rd] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (iss_valid && (iss_rd != {AW{1'b0}})) begin
            pending_nxt_s[iss_rd] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Registered write port and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            port_r    <= '{we: 1'b0, addr: {AW{1'b0}}, data: {XLEN{1'b0}}};
            pending_r <= {NREG{1'b0}};
        end else begin
            port_r    <= port_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    assign rf_we    = port_r.we;
    assign rf_waddr = port_r.addr;
    assign rf_wdata = port_r.data;

    // The register file writes on the falling edge, so busy may drop in the write cycle.
    assign busy1 = (rs1 != {AW{1'b0}}) && pending_r[rs1];
    assign busy2 = (rs2 != {AW{1'b0}}) && pending_r[rs2];

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
Writeback-side controller that drives the register file's single write port (we/addr/data). It merges two producers:
- the in-order pipeline WB result (ALU path, cannot stall);
- long-latency completions from the load/store unit, via a valid/ready handshake and a small FIFO.

It also keeps a pending-destination scoreboard so decode can stall on registers that are still owed a long-latency write.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)
FIFO_DEPTH, 2, long-latency result buffer entries (power of two, >=2)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  pipeline WB result present this cycle
alu_rd  input  AW  pipeline destination register
alu_wdata  input  XLEN  pipeline result
lsu_valid  input  1  long-latency result offered
lsu_ready  output  1  FIFO can accept; equals !full
lsu_rd  input  AW  long-latency destination
lsu_wdata  input  XLEN  long-latency result
iss_valid  input  1  a long-latency op issues this cycle
iss_rd  input  AW  its destination
rs1  input  AW  decode source query 1
rs2  input  AW  decode source query 2
busy1  output  1  rs1 has an outstanding long-latency write
busy2  output  1  rs2 has an outstanding long-latency write
rf_we  output  1  register file write enable, registered
rf_waddr  output  AW  register file write address, registered
rf_wdata  output  XLEN  register file write data, registered

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO emptied; lsu_ready=1 the following cycle.
  - All pending bits cleared; busy1=busy2=0.
  - In-flight entries are discarded, including during mid-drain.
- Write port outputs are registered. The register file samples them on the falling edge of the same cycle they are driven.
- Slot arbitration in cycle T (fixed priority, pipeline wins):
  - alu_valid && alu_rd!=0: at T+1, rf_we=1, rf_waddr=alu_rd, rf_wdata=alu_wdata.
  - Otherwise, if FIFO non-empty: pop head; at T+1, rf_we = (head.rd != 0), with head's rd and data.
  - Otherwise: rf_we=0 at T+1; addr/data hold their previous values.
- x0 rules:
  - alu_valid with alu_rd=0 is a bubble and leaves the slot free for the FIFO.
  - A FIFO head with rd=0 is popped and dropped; no write is performed.
- LSU handshake:
  - Transfer occurs when lsu_valid && lsu_ready at a rising edge.
  - lsu_ready = !full, independent of a same-cycle pop (no push-when-full-with-pop).
  - No bypass: an accepted entry is written no earlier than 2 cycles after acceptance (accept T, pop ≥ T+1, rf_we ≥ T+2).
  - Entries drain in strict FIFO order.
  - The LSU must hold lsu_rd and lsu_wdata while lsu_valid && !lsu_ready.
- Scoreboard: pending[NREG] bits, pending[0] hardwired 0.
  - Set: iss_valid && iss_rd!=0 sets pending[iss_rd] at the next edge.
  - Clear: a FIFO pop with rd!=0 clears pending[rd] at the same edge that raises rf_we for that entry.
  - Set and clear of the same register in one cycle: set wins; the newer op is still owed.
  - busy1 = pending[rs1]; busy2 = pending[rs2] (combinational from the register state); 0 when rs=0.
  - busy deasserts in the cycle the write is on the port. The falling-edge write makes data readable in that cycle's second half, so decode may proceed.
- ALU write to a pending register: the write is performed and the pending bit is unchanged. Decode is required to stall WAW against busy, so this case is not expected in correct operation.
- Count logic: occupancy counter 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package: XLEN, AW, NREG constants; a typedef for the write-port bundle {we, addr, data}; a typedef for the FIFO entry {rd, data}.
- One natural sub-module: wb_result_fifo (parameterised depth/width synchronous FIFO with full/empty/count, synchronous active-high reset).
- Arbitration and scoreboard stay in the top module.

Test Plan:
1. ALU write: alu_valid=1, alu_rd=5, alu_wdata=0xDEADBEEF at T -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at T+1; rf_we=0 at T+2 when idle.
2. x0 suppression: alu_valid=1, alu_rd=0 with FIFO holding {rd=3, 0x11} -> FIFO entry written at T+1 (rf_waddr=3); a LSU result with rd=0 is consumed with no rf_we.
3. LSU lifecycle: iss rd=7 at T0 -> busy1=1 for rs1=7 from T0+1; lsu_wdata=0x1234 accepted at T5 with ALU idle -> rf_we, waddr 7, wdata 0x1234 at T7, busy1=0 in T7.
4. Contention: alu_valid=1 (rd=1..4) for 4 cycles while LSU offers rd 10, 11, 12 back-to-back -> lsu_ready drops after 2 accepts; ALU writes occupy 4 consecutive cycles; then 10, 11, 12 are written in order with no loss.
5. Set/clear collision: pending[9]=1; FIFO pops rd=9 in the same cycle iss_valid with iss_rd=9 -> rf_we for 9 occurs, busy for rs=9 stays 1.
6. Reset mid-operation: FIFO full (2 entries), pending bits set, rst=1 for one cycle -> next cycle rf_we=0, lsu_ready=1, busy1=busy2=0 for all rs; no discarded entry ever written.
